// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle restoring divider.
package div_pkg;

  localparam int unsigned WIDTH = 32;

  // Quotient reported when the divisor is zero
  localparam logic [WIDTH-1:0] DIVZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    DIVZERO = 2'b01,
    ON      = 2'b10,
    END     = 2'b11
  } div_state_e;

  // Two's-complement negate when en is set, wrapping at WIDTH bits
  function automatic logic [WIDTH-1:0] neg_if(input logic en, input logic [WIDTH-1:0] x);
    return en ? (-x) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_c_o,
  output logic             qbit_c_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           unused_rem_msb;

  // The partial remainder is always below the divisor, so its top bit never carries data
  assign unused_rem_msb = rem_i[WIDTH];

  // Trial subtraction; a clear sign bit means the divisor fits
  always_comb begin
    shifted  = {rem_i[WIDTH-1:0], dvd_bit_i};
    trial    = shifted - {1'b0, divisor_i};
    qbit_c_o = ~trial[WIDTH];
    rem_c_o  = qbit_c_o ? trial : shifted;
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit feeding HI (remainder) and LO (quotient).
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] opdata1,
  input  logic [WIDTH-1:0] opdata2,
  input  logic             annul,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             we_hi,
  output logic             we_lo
);

  import div_pkg::*;

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] quot_next;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[WIDTH-1]),
    .divisor_i (dsr_q),
    .rem_c_o   (step_rem),
    .qbit_c_o  (step_qbit)
  );

  assign quot_next = {dvd_q[WIDTH-2:0], step_qbit};

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state, iteration and result logic; results are staged into the END cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE: begin
        if (start && !annul) begin
          busy_d  = 1'b1;
          cnt_d   = '0;
          rem_d   = '0;
          qsign_d = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
          rsign_d = signed_div & opdata1[WIDTH-1];
          if (opdata2 == '0) begin
            state_d = DIVZERO;
            dvd_d   = opdata1;
          end else begin
            state_d = ON;
            dvd_d   = neg_if(signed_div & opdata1[WIDTH-1], opdata1);
            dsr_d   = neg_if(signed_div & opdata2[WIDTH-1], opdata2);
          end
        end
      end
      DIVZERO: begin
        if (annul) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = END;
          done_d  = 1'b1;
          hi_d    = dvd_q;
          lo_d    = DIVZERO_QUOT;
        end
      end
      ON: begin
        if (annul) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          rem_d = step_rem;
          dvd_d = quot_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = END;
            done_d  = 1'b1;
            lo_d    = neg_if(qsign_q, quot_next);
            hi_d    = neg_if(rsign_q, step_rem[WIDTH-1:0]);
          end
        end
      end
      END: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign we_hi  = done_q;
  assign we_lo  = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the MIPS execute stage, serving DIV and DIVU. Sits directly upstream of the HI/LO register: it produces the remainder for HI and the quotient for LO, together with their write enables. The EX stage stalls while the divider is busy. Radix-2 restoring division processes one quotient bit per cycle.

## Interface
Parameters:
- WIDTH, 32, operand and result width. Only 32 is supported.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset; asserted while 0.
- start  in  1  request a division; sampled only in IDLE.
- signed_div  in  1  1 selects DIV (signed), 0 selects DIVU; sampled with start.
- opdata1  in  32  dividend; sampled with start.
- opdata2  in  32  divisor; sampled with start.
- annul  in  1  cancel an in-flight division (exception or flush).
- busy  out  1  a division is in progress; EX must stall.
- done  out  1  one-cycle pulse; results are valid.
- hi_out  out  32  remainder.
- lo_out  out  32  quotient.
- we_hi  out  1  HI write enable; equals done.
- we_lo  out  1  LO write enable; equals done.

## Operation
- States are IDLE, DIVZERO, ON and END. All outputs are registered.
- On reset, state goes to IDLE and busy, done, we_hi, we_lo, hi_out, lo_out and the iteration counter all go to 0.
- IDLE with start=1 and opdata2≠0: latch |opdata1| and |opdata2| (absolute values only when signed_div=1), the quotient sign (sign1^sign2) and the remainder sign (sign1), then go to ON with count=0.
- IDLE with start=1 and opdata2=0: go to DIVZERO.
- DIVZERO goes to END with remainder=opdata1 and quotient=0xFFFFFFFF, with no sign fix-up.
- ON performs one step per cycle:
  - Form the 33-bit trial value {rem[31:0], next dividend bit} − divisor.
  - If the trial is non-negative, keep it and shift in quotient bit 1; otherwise keep the old value and shift in 0.
  - After the 32nd step (count=31), apply sign fix-up in two's complement, wrapping at 32 bits, and go to END.
- Sign-corner cases:
  - 0x80000000 / 0xFFFFFFFF signed gives LO=0x80000000, HI=0.
  - Unsigned operands are never negated.
- END asserts done, we_hi and we_lo for exactly one cycle, drives the final hi_out/lo_out, then returns to IDLE.
- hi_out and lo_out hold their values until the next END.
- start is ignored in every state except IDLE. There is no queueing.
- annul=1 in DIVZERO or ON returns to IDLE at the next edge:
  - No done or we pulse is generated.
  - hi_out and lo_out keep their previous values.
  - busy drops with the IDLE transition.
- annul in END has no effect: the write commits.
- annul in IDLE has priority over start: the request is dropped.
- Reset asserted mid-operation aborts immediately to reset values.

## Timing
- Normal division: start is high in cycle 0; ON occupies cycles 1–32; END is cycle 33 (done=1); IDLE resumes at cycle 34.
- busy is high in cycles 1–33.
- Divide-by-zero: DIVZERO is cycle 1, END (done) is cycle 2, and busy is high in cycles 1–2.
- Back-to-back: a new start is accepted in cycle 34 at the earliest.
- HI/LO capture we/hi/lo on the falling edge within the done cycle, so outputs must be stable from the rising edge that starts that cycle.

## Structure
- Shared package div_pkg holds:
  - the state encoding (IDLE=2'b00, DIVZERO=2'b01, ON=2'b10, END=2'b11);
  - the WIDTH constant;
  - the DIVZERO quotient constant 32'hFFFFFFFF.
- One sub-module, div_step: a combinational restoring step. It takes the 33-bit partial remainder, the next dividend bit and the divisor, and returns the new partial remainder and the quotient bit.
- The state machine, counter, operand latches and sign fix-up stay in div_unit.

## Test plan
- DIVU 100/7 → done at cycle 33, LO=14, HI=2, we_hi=we_lo=1 for exactly one cycle, busy high in cycles 1–33.
- DIV −7/2 (0xFFFFFFF9/2) → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). Also DIV 7/−2 → LO=−3, HI=1.
- DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 0xFFFFFFFF/1 → LO=0xFFFFFFFF, HI=0.
- DIVU 5/0 → done at cycle 2, LO=0xFFFFFFFF, HI=5.
- Abort cases:
  - annul pulsed in cycle 10 → no done ever, busy low from cycle 11, hi_out/lo_out unchanged.
  - start held during busy → ignored.
  - rst low in cycle 20 → all outputs 0 immediately.
- Back-to-back: second start in cycle 34 → second done at cycle 67 with correct results; the first results hold in cycles 34–66.
